// File: rtl/text_ram_write_arbiter_if.sv
// Requester-side write bus for the text RAM arbiter: per-requester level
// requests with packed address/data, and the one-hot grant returned to them.
interface text_ram_write_arbiter_if #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 8
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        gnt;

  modport master (output req, output req_addr, output req_data, input gnt);
  modport slave  (input req, input req_addr, input req_data, output gnt);
endinterface

// File: rtl/text_ram_write_arbiter.sv
// Single-owner write port for the 70x30 text RAM: round-robin arbitration
// among NREQ requesters plus a zero-fill clear sequencer.
module text_ram_write_arbiter #(
  parameter int unsigned NREQ         = 3,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned SCREEN_CELLS = 2100
) (
  input  logic                      clk,
  input  logic                      reset_n,
  text_ram_write_arbiter_if.slave   wr,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_data,
  output logic                      ram_wren,
  output logic                      err_oob
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(SCREEN_CELLS - 1);
  localparam logic [ADDR_W-1:0] N_CELLS   = ADDR_W'(SCREEN_CELLS);
  localparam logic [PTR_W-1:0]  LAST_REQ  = PTR_W'(NREQ - 1);

  typedef enum logic [0:0] {ST_ARB, ST_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                wren_q, wren_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                oob_q, oob_d;

  logic [NREQ-1:0]     eligible;
  logic [ADDR_W-1:0]   addr_arr [NREQ];
  logic [DATA_W-1:0]   data_arr [NREQ];
  logic [PTR_W-1:0]    win, idx;
  logic                found, arb_en;
  int unsigned         sum;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_ARB;
      rr_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      oob_q   <= oob_d;
    end
  end

  // Round-robin pick; a requester granted last cycle is masked so a req drop on gnt is safe
  always_comb begin
    eligible = wr.req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    sum      = 0;
    for (int i = 0; i < NREQ; i++) begin
      addr_arr[i] = wr.req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = wr.req_data[i*DATA_W +: DATA_W];
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = 32'(rr_q) + k;
      idx = PTR_W'(sum % NREQ);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    oob_d   = 1'b0;
    arb_en  = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          addr_d  = '0;
          data_d  = '0;
          wren_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          arb_en = 1'b1;
        end
      end
      ST_CLEAR: begin
        // cnt_q is the cell being written this cycle; clr_start is ignored here
        if (cnt_q == LAST_CELL) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
          arb_en  = 1'b1;
        end else begin
          cnt_d  = cnt_q + ADDR_W'(1);
          addr_d = cnt_q + ADDR_W'(1);
          data_d = '0;
          wren_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (arb_en && found) begin
      gnt_d[win] = 1'b1;
      addr_d     = addr_arr[win];
      data_d     = data_arr[win];
      oob_d      = (addr_arr[win] >= N_CELLS);
      wren_d     = (addr_arr[win] < N_CELLS);
      rr_d       = (win == LAST_REQ) ? '0 : win + PTR_W'(1);
    end
  end

  assign wr.gnt   = gnt_q;
  assign ram_addr = addr_q;
  assign ram_data = data_q;
  assign ram_wren = wren_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;
  assign err_oob  = oob_q;

endmodule

// File: tb/tb_text_ram_write_arbiter.sv
// Directed bench for text_ram_write_arbiter: round-robin order, grant masking,
// out-of-range writes, clear sequencing and reset abort.
module tb_text_ram_write_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              clr_start;
  logic              clr_busy, clr_done, ram_wren, err_oob;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  text_ram_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  text_ram_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCREEN_CELLS(2100)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr        (bus),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .err_oob   (err_oob)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset;
    reset_n   = 1'b0;
    clr_start = 1'b0;
    bus.req   = '0;
    step;
    step;
  endtask

  task automatic test_reset;
    logic [ADDR_W-1:0] ea [3];
    logic [DATA_W-1:0] ed [3];
    logic [NREQ-1:0]   eg;
    int                ix;
    ea = '{12'd10, 12'd20, 12'd30};
    ed = '{8'h30, 8'h41, 8'h42};
    reset_n = 1'b0; clr_start = 1'b0; bus.req = 3'b111;
    set_req(0, 12'd10, 8'h30); set_req(1, 12'd20, 8'h41); set_req(2, 12'd30, 8'h42);
    step; step;
    n_cmp++;
    if ({bus.gnt, ram_wren, clr_busy, clr_done, err_oob, ram_addr, ram_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b wren=%b busy=%b done=%b oob=%b addr=%0d data=%h, want all zero",
               bus.gnt, ram_wren, clr_busy, clr_done, err_oob, ram_addr, ram_data);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      ix = k % 3;
      eg = 3'b001 << ix;
      n_cmp++;
      if (bus.gnt !== eg || ram_wren !== 1'b1 || ram_addr !== ea[ix] || ram_data !== ed[ix] || err_oob !== 1'b0) begin
        n_bad++;
        $display("FAIL rr_all_three[%0d]: got gnt=%b wren=%b addr=%0d data=%h oob=%b, want gnt=%b wren=1 addr=%0d data=%h oob=0",
                 k, bus.gnt, ram_wren, ram_addr, ram_data, err_oob, eg, ea[ix], ed[ix]);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_single_requester;
    logic [NREQ-1:0] eg;
    logic            ew;
    do_reset;
    bus.req = 3'b010;
    set_req(1, 12'd140, 8'h61);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step;
      eg = (k % 2 == 0) ? 3'b010 : 3'b000;
      ew = (k % 2 == 0);
      n_cmp++;
      if (bus.gnt !== eg || ram_wren !== ew || (ew && (ram_addr !== 12'd140 || ram_data !== 8'h61))) begin
        n_bad++;
        $display("FAIL single_req1[%0d]: got gnt=%b wren=%b addr=%0d data=%h, want gnt=%b wren=%b addr=140 data=61",
                 k, bus.gnt, ram_wren, ram_addr, ram_data, eg, ew);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_pair_alternate;
    logic [NREQ-1:0]   eg;
    logic [ADDR_W-1:0] ea;
    do_reset;
    bus.req = 3'b101;
    set_req(0, 12'd5, 8'h10);
    set_req(2, 12'd2000, 8'h20);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      eg = (k % 2 == 0) ? 3'b001 : 3'b100;
      ea = (k % 2 == 0) ? 12'd5 : 12'd2000;
      n_cmp++;
      if (bus.gnt !== eg || ram_wren !== 1'b1 || ram_addr !== ea) begin
        n_bad++;
        $display("FAIL pair_0_2[%0d]: got gnt=%b wren=%b addr=%0d, want gnt=%b wren=1 addr=%0d",
                 k, bus.gnt, ram_wren, ram_addr, eg, ea);
      end
    end
    bus.req = '0;
  endtask

  task automatic test_oob;
    do_reset;
    bus.req = 3'b001;
    set_req(0, 12'd2100, 8'h55);
    reset_n = 1'b1;
    step;
    n_cmp++;
    if (bus.gnt !== 3'b001 || err_oob !== 1'b1 || ram_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_2100: got gnt=%b oob=%b wren=%b, want gnt=001 oob=1 wren=0", bus.gnt, err_oob, ram_wren);
    end
    set_req(0, 12'd2099, 8'h56);
    step;
    n_cmp++;
    if (bus.gnt !== 3'b000 || err_oob !== 1'b0 || ram_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_masked_gap: got gnt=%b oob=%b wren=%b, want gnt=000 oob=0 wren=0", bus.gnt, err_oob, ram_wren);
    end
    step;
    n_cmp++;
    if (bus.gnt !== 3'b001 || err_oob !== 1'b0 || ram_wren !== 1'b1 || ram_addr !== 12'd2099 || ram_data !== 8'h56) begin
      n_bad++;
      $display("FAIL last_cell_2099: got gnt=%b oob=%b wren=%b addr=%0d data=%h, want gnt=001 oob=0 wren=1 addr=2099 data=56",
               bus.gnt, err_oob, ram_wren, ram_addr, ram_data);
    end
    bus.req = '0;
  endtask

  task automatic test_clear_pending;
    int bad_cycles;
    int first_bad;
    do_reset;
    reset_n = 1'b1;
    step;
    clr_start = 1'b1;
    bus.req   = 3'b100;
    set_req(2, 12'd77, 8'h5a);
    step;
    clr_start  = 1'b0;
    bad_cycles = 0;
    first_bad  = -1;
    for (int c = 0; c < 2100; c++) begin
      if ({bus.gnt, ram_wren, clr_busy, clr_done, ram_addr, ram_data} !== {3'b000, 1'b1, 1'b1, 1'b0, 12'(c), 8'h00}) begin
        if (first_bad < 0) first_bad = c;
        bad_cycles++;
      end
      if (c < 2099) step;
    end
    n_cmp++;
    if (bad_cycles !== 0) begin
      n_bad++;
      $display("FAIL clear_sweep: got %0d bad cycles (first at cell %0d), want 0", bad_cycles, first_bad);
    end
    step;
    n_cmp++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || bus.gnt !== 3'b100 || ram_wren !== 1'b1 ||
        ram_addr !== 12'd77 || ram_data !== 8'h5a) begin
      n_bad++;
      $display("FAIL clear_end_grant: got done=%b busy=%b gnt=%b wren=%b addr=%0d data=%h, want done=1 busy=0 gnt=100 wren=1 addr=77 data=5a",
               clr_done, clr_busy, bus.gnt, ram_wren, ram_addr, ram_data);
    end
    bus.req = '0;
    step;
    n_cmp++;
    if (clr_done !== 1'b0 || bus.gnt !== 3'b000 || ram_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_done_pulse: got done=%b gnt=%b wren=%b, want done=0 gnt=000 wren=0", clr_done, bus.gnt, ram_wren);
    end
  endtask

  task automatic test_clear_restart_ignored;
    int bad_cycles;
    int done_seen;
    do_reset;
    reset_n = 1'b1;
    step;
    clr_start = 1'b1;
    step;
    clr_start  = 1'b0;
    bad_cycles = 0;
    done_seen  = 0;
    for (int c = 0; c < 2100; c++) begin
      if (ram_addr !== 12'(c) || ram_wren !== 1'b1 || clr_busy !== 1'b1) bad_cycles++;
      if (clr_done === 1'b1) done_seen++;
      if (c == 500) clr_start = 1'b1;
      if (c < 2099) step;
      clr_start = 1'b0;
    end
    n_cmp++;
    if (bad_cycles !== 0 || done_seen !== 0) begin
      n_bad++;
      $display("FAIL clear_repulse_sweep: got %0d bad cycles, %0d early done, want 0 and 0", bad_cycles, done_seen);
    end
    step;
    n_cmp++;
    if (clr_done !== 1'b1 || clr_busy !== 1'b0 || ram_wren !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_repulse_end: got done=%b busy=%b wren=%b, want done=1 busy=0 wren=0", clr_done, clr_busy, ram_wren);
    end
    done_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step;
      if (clr_done !== 1'b0 || clr_busy !== 1'b0 || ram_wren !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_bad++;
      $display("FAIL clear_no_rerun: got %0d cycles with done/busy/wren set after clear, want 0", done_seen);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [NREQ-1:0] eg;
    do_reset;
    reset_n = 1'b1;
    set_req(0, 12'd10, 8'h30); set_req(1, 12'd20, 8'h41); set_req(2, 12'd30, 8'h42);
    clr_start = 1'b1;
    bus.req   = 3'b111;
    step;
    clr_start = 1'b0;
    for (int c = 0; c < 1000; c++) step;
    n_cmp++;
    if (ram_addr !== 12'd1000 || clr_busy !== 1'b1 || bus.gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL clear_at_1000: got addr=%0d busy=%b gnt=%b, want addr=1000 busy=1 gnt=000", ram_addr, clr_busy, bus.gnt);
    end
    reset_n = 1'b0;
    step;
    n_cmp++;
    if (ram_wren !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0 || bus.gnt !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_abort: got wren=%b busy=%b done=%b gnt=%b, want all 0", ram_wren, clr_busy, clr_done, bus.gnt);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step;
      eg = 3'b001 << k;
      n_cmp++;
      if (bus.gnt !== eg || clr_done !== 1'b0 || clr_busy !== 1'b0 || ram_wren !== 1'b1) begin
        n_bad++;
        $display("FAIL post_abort_rr[%0d]: got gnt=%b done=%b busy=%b wren=%b, want gnt=%b done=0 busy=0 wren=1",
                 k, bus.gnt, clr_done, clr_busy, ram_wren, eg);
      end
    end
    bus.req = '0;
  endtask

  initial begin
    reset_n      = 1'b0;
    clr_start    = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    test_reset;
    test_single_requester;
    test_pair_alternate;
    test_oob;
    test_clear_pending;
    test_clear_restart_ignored;
    test_reset_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
